// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// the internal request bundle and a small index helper.
package dmem_arbiter_pkg;

    localparam int unsigned word_width_lp = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RETURN = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        byte_not_word;
    } mem_req_s;

    // Increment an index modulo n (n >= 1).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or
// above the pointer, wrapping around.
module rr_pick #(
    parameter int num_req_p  = 4,
    parameter int id_width_p = 2
) (
    input  logic [num_req_p-1:0]  req_i,
    input  logic [id_width_p-1:0] ptr_i,
    output logic [id_width_p-1:0] grant_o,
    output logic                  found_o
);

    logic [id_width_p-1:0] idx_s;
    logic                  hit_s;

    // Scan num_req_p positions starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            idx_s   = id_width_p'((int'(ptr_i) + i) % num_req_p);
            hit_s   = !found_o && req_i[idx_s];
            grant_o = hit_s ? idx_s : grant_o;
            found_o = found_o | hit_s;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between num_req_p cores,
// one transaction in flight. Optional perf counters: DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int num_req_p  = 4,
    parameter int id_width_p = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [num_req_p-1:0]      req_valid_i,
    input  logic [num_req_p*32-1:0]   req_addr_i,
    input  logic [num_req_p*32-1:0]   req_wdata_i,
    input  logic [num_req_p-1:0]      req_wen_i,
    input  logic [num_req_p-1:0]      req_byte_i,
    output logic [num_req_p-1:0]      req_yumi_o,
    output logic [num_req_p-1:0]      resp_valid_o,
    output logic [31:0]               resp_data_o,
    input  logic [num_req_p-1:0]      resp_yumi_i,
    output logic                      mem_valid_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    output logic                      mem_wen_o,
    output logic                      mem_byte_o,
    input  logic                      mem_yumi_i,
    input  logic                      mem_resp_valid_i,
    input  logic [31:0]               mem_resp_data_i,
    output logic                      mem_resp_yumi_o,
`ifdef DMEM_ARB_PERF_CNT_EN
    output logic [num_req_p*32-1:0]   perf_grant_cnt_o,
    output logic [31:0]               perf_wait_cnt_o,
`endif
    output logic                      busy_o,
    output logic [id_width_p-1:0]     grant_id_o
);

    import dmem_arbiter_pkg::*;

    arb_state_e                 state_r;
    logic [id_width_p-1:0]      ptr_r;
    logic [id_width_p-1:0]      grant_r;
    logic [word_width_lp-1:0]   resp_data_r;

    logic [id_width_p-1:0]      pick_s;
    logic                       found_s;
    logic [id_width_p-1:0]      next_ptr_s;
    logic [num_req_p-1:0]       grant_oh_s;
    mem_req_s                   req_sel_s;
    logic                       issue_s;
    logic                       return_s;
    logic                       accept_s;

    rr_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_p)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_r),
        .grant_o (pick_s),
        .found_o (found_s)
    );

    assign issue_s    = (state_r == ARB_ISSUE);
    assign return_s   = (state_r == ARB_RETURN);
    assign accept_s   = issue_s && mem_yumi_i;
    assign next_ptr_s = id_width_p'(wrap_inc(32'(grant_r), 32'(num_req_p)));

    // One-hot of the held grant index, used for yumi and response steering.
    always_comb begin
        grant_oh_s          = '0;
        grant_oh_s[grant_r] = 1'b1;
    end

    // Select the granted core's request fields.
    always_comb begin
        req_sel_s               = '0;
        req_sel_s.addr          = req_addr_i[int'(grant_r)*32 +: 32];
        req_sel_s.wdata         = req_wdata_i[int'(grant_r)*32 +: 32];
        req_sel_s.wen           = req_wen_i[grant_r];
        req_sel_s.byte_not_word = req_byte_i[grant_r];
    end

    // Request fields are zeroed outside ISSUE so memory never sees stale data.
    assign mem_valid_o     = issue_s;
    assign mem_addr_o      = issue_s ? req_sel_s.addr  : 32'd0;
    assign mem_wdata_o     = issue_s ? req_sel_s.wdata : 32'd0;
    assign mem_wen_o       = issue_s && req_sel_s.wen;
    assign mem_byte_o      = issue_s && req_sel_s.byte_not_word;
    assign req_yumi_o      = accept_s ? grant_oh_s : '0;
    assign mem_resp_yumi_o = (state_r == ARB_WAIT) && mem_resp_valid_i;
    assign resp_valid_o    = return_s ? grant_oh_s : '0;
    assign resp_data_o     = return_s ? resp_data_r : 32'd0;
    assign busy_o          = (state_r != ARB_IDLE);
    assign grant_id_o      = grant_r;

    // Transaction FSM: grant, issue, wait for memory, return to core.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ARB_IDLE;
            ptr_r       <= '0;
            grant_r     <= '0;
            resp_data_r <= '0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (found_s) begin
                        grant_r <= pick_s;
                        state_r <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_yumi_i) begin
                        ptr_r   <= next_ptr_s;
                        state_r <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_resp_valid_i) begin
                        resp_data_r <= mem_resp_data_i;
                        state_r     <= ARB_RETURN;
                    end
                end
                ARB_RETURN: begin
                    if (resp_yumi_i[grant_r]) begin
                        state_r <= ARB_IDLE;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [num_req_p*32-1:0] perf_grant_cnt_r;
    logic [31:0]             perf_wait_cnt_r;
    logic [num_req_p-1:0]    granted_mask_s;
    logic                    waiting_s;

    // A core only counts as granted while a transaction is in progress.
    assign granted_mask_s   = busy_o ? grant_oh_s : '0;
    assign waiting_s        = |(req_valid_i & ~granted_mask_s);
    assign perf_grant_cnt_o = perf_grant_cnt_r;
    assign perf_wait_cnt_o  = perf_wait_cnt_r;

    // Free-running wrap-around counters for grants and starved cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant_cnt_r <= '0;
            perf_wait_cnt_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                perf_grant_cnt_r[int'(grant_r)*32 +: 32] <= perf_grant_cnt_r[int'(grant_r)*32 +: 32] + 32'd1;
            end
            if (waiting_s) begin
                perf_wait_cnt_r <= perf_wait_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, scoreboard and
// hand-written sequences for round-robin, backpressure and reset.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_wen, req_byte, req_yumi;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]    resp_valid, resp_yumi, consume_en;
    logic [31:0]     resp_data;
    logic            mem_valid, mem_wen, mem_byte, mem_yumi;
    logic [31:0]     mem_addr, mem_wdata, mem_resp_data;
    logic            mem_resp_valid, mem_resp_yumi, busy;
    logic [IW-1:0]   grant_id;

    always #5 clk = ~clk;

    dmem_arbiter #(.num_req_p(N), .id_width_p(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wen_i(req_wen), .req_byte_i(req_byte), .req_yumi_o(req_yumi),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
        .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wen_o(mem_wen), .mem_byte_o(mem_byte), .mem_yumi_i(mem_yumi),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_data_i(mem_resp_data),
        .mem_resp_yumi_o(mem_resp_yumi), .busy_o(busy), .grant_id_o(grant_id)
    );

    // Memory model: accepts after yumi_delay cycles, answers resp_delay cycles after WAIT starts.
    int          yumi_delay, resp_delay, issue_cnt, resp_cnt, cycle;
    logic        pending, auto_rereq;
    logic [31:0] pend_data, pend_next;

    assign mem_yumi       = mem_valid && (issue_cnt >= yumi_delay);
    assign mem_resp_valid = pending && (resp_cnt >= resp_delay);
    assign mem_resp_data  = mem_resp_valid ? pend_data : 32'hBAD0_BAD0;
    assign resp_yumi      = resp_valid & consume_en;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0] s_yumi, s_rvalid;
    logic         s_mvalid, s_accept, s_mresp, s_busy, s_wen, s_byte;
    logic [31:0]  s_addr, s_wdata, s_rdata;
    logic [IW-1:0] s_gid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    endtask

    function automatic logic [N-1:0] oh(input int c);
        logic [N-1:0] one_v;
        one_v = 4'b0001;
        return one_v << c;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a, input logic [31:0] wd, input logic w);
        return w ? wd : (a ^ 32'h5A5A_0000);
    endfunction

    // Sample at negedge, score consumed responses, then advance the models after the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_yumi = req_yumi;   s_mvalid = mem_valid; s_accept = mem_valid && mem_yumi;
        s_addr = mem_addr;   s_wdata = mem_wdata;  s_wen = mem_wen; s_byte = mem_byte;
        s_rvalid = resp_valid; s_rdata = resp_data; s_mresp = mem_resp_yumi;
        s_busy = busy;       s_gid = grant_id;
        if (s_accept) pend_next = mem_data(mem_addr, mem_wdata, mem_wen);
        if ((resp_valid & resp_yumi) != '0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_core", 32'(resp_valid), 32'(oh(e.core)));
                check("sb_data", resp_data, e.data);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (cycle > 5000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 5000", cycle);
            $fatal(1, "watchdog");
        end
        if (reset) begin
            pending = 1'b0; issue_cnt = 0; resp_cnt = 0;
        end else begin
            if (s_accept) begin
                pending = 1'b1; resp_cnt = 0; issue_cnt = 0; pend_data = pend_next;
            end else if (s_mvalid) begin
                issue_cnt++;
            end
            if (s_mresp) pending = 1'b0;
            else if (pending && !s_accept) resp_cnt++;
        end
        if (!auto_rereq) req_valid = req_valid & ~s_yumi;
    endtask

    task automatic request(input int c, input logic [31:0] a, input logic [31:0] wd,
                           input logic w, input logic b, input logic push);
        exp_t e;
        req_addr[c*32 +: 32]  = a;
        req_wdata[c*32 +: 32] = wd;
        req_wen[c]   = w;
        req_byte[c]  = b;
        req_valid[c] = 1'b1;
        if (push) begin
            e.core = c; e.data = mem_data(a, wd, w);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((s_busy || req_valid != '0 || sb_q.size() != 0) && k < 200);
        check(name, 32'(k < 200), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int          core;
        logic [31:0] addr, wdata;
        logic        wen, byt;
        int          yd, rd;
        logic [31:0] exp_data;
        int          exp_lat, exp_mv;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   grants[5];
        int   acc_cyc[5];
        int   n, lat, mv;
        logic [31:0] held;

        reset = 1'b1; req_valid = '0; req_wen = '0; req_byte = '0; req_addr = '0; req_wdata = '0;
        consume_en = '1; yumi_delay = 0; resp_delay = 0; issue_cnt = 0; resp_cnt = 0;
        pending = 1'b0; pend_data = 32'd0; pend_next = 32'd0; auto_rereq = 1'b0; cycle = 0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_mvalid", 32'(s_mvalid), 32'd0);
        check("rst_yumi", 32'(s_yumi), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_gid", 32'(s_gid), 32'd0);

        vecs[0] = '{2, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 0, 32'hDEAD_BEEF, 3, 1};
        vecs[1] = '{0, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 0, 0, 32'h5A5A_0100, 3, 1};
        vecs[2] = '{3, 32'h5A5A_1234, 32'h0000_0000, 1'b0, 1'b1, 5, 3, 32'h0000_1234, 11, 6};
        vecs[3] = '{1, 32'h0000_0007, 32'h0000_00AB, 1'b1, 1'b1, 1, 2, 32'h0000_00AB, 6, 2};

        for (int v = 0; v < 4; v++) begin
            yumi_delay = vecs[v].yd;
            resp_delay = vecs[v].rd;
            request(vecs[v].core, vecs[v].addr, vecs[v].wdata, vecs[v].wen, vecs[v].byt, 1'b1);
            lat = -1; mv = 0;
            for (int k = 0; k < 40 && lat < 0; k++) begin
                tick();
                if (s_mvalid) begin
                    mv++;
                    check("vec_addr", s_addr, vecs[v].addr);
                    check("vec_wdata", s_wdata, vecs[v].wdata);
                    check("vec_wen", 32'(s_wen), 32'(vecs[v].wen));
                    check("vec_byte", 32'(s_byte), 32'(vecs[v].byt));
                    check("vec_yumi", 32'(s_yumi), s_accept ? 32'(oh(vecs[v].core)) : 32'd0);
                end
                if (s_rvalid != '0) begin
                    lat = k;
                    check("vec_rvalid", 32'(s_rvalid), 32'(oh(vecs[v].core)));
                    check("vec_rdata", s_rdata, vecs[v].exp_data);
                end
            end
            check("vec_latency", lat, vecs[v].exp_lat);
            check("vec_mvalid_cycles", mv, vecs[v].exp_mv);
            drain("vec_drain");
        end

        // Round-robin from pointer 0 with all cores requesting continuously
        pulse_reset();
        yumi_delay = 0; resp_delay = 0;
        for (int c = 0; c < N; c++) request(c, 32'h200 + 32'(4 * c), 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sb_q.push_back('{i % N, (32'h200 + 32'(4 * (i % N))) ^ 32'h5A5A_0000});
        auto_rereq = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 5; k++) begin
            tick();
            if (s_accept) begin
                grants[n] = int'(s_yumi); acc_cyc[n] = cycle; n++;
                if (n == 5) begin auto_rereq = 1'b0; req_valid = '0; end
            end
        end
        check("rr_grant_count", n, 5);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", grants[i], 32'(oh(i % N)));
            if (i > 0) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
        end
        drain("rr_drain");

        // Slow consumer: core 1 holds its response while cores 3 and 0 wait
        consume_en = 4'b1101;
        request(1, 32'h300, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        request(3, 32'h304, 32'd0, 1'b0, 1'b0, 1'b1);
        request(0, 32'h308, 32'h5555_AAAA, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (s_rvalid == '0 && n < 20) begin tick(); n++; end
        check("slow_resp_seen", 32'(s_rvalid), 32'b0010);
        held = s_rdata;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("slow_rvalid", 32'(s_rvalid), 32'b0010);
            check("slow_rdata", s_rdata, held);
            check("slow_no_mvalid", 32'(s_mvalid), 32'd0);
        end
        consume_en = '1;
        drain("slow_drain");

        // Reset while waiting on memory: next grant must restart from core 0
        resp_delay = 10;
        request(2, 32'h400, 32'd0, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!s_accept && n < 20);
        tick();
        check("wait_busy", 32'(s_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        tick();
        check("rwait_busy", 32'(s_busy), 32'd0);
        check("rwait_mvalid", 32'(s_mvalid), 32'd0);
        check("rwait_rvalid", 32'(s_rvalid), 32'd0);
        check("rwait_mresp", 32'(s_mresp), 32'd0);
        check("rwait_gid", 32'(s_gid), 32'd0);
        resp_delay = 0;
        request(0, 32'h500, 32'd0, 1'b0, 1'b0, 1'b1);
        request(3, 32'h504, 32'd0, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!s_accept && n < 20);
        check("rwait_first_grant", 32'(s_yumi), 32'b0001);
        drain("rwait_drain");

        check("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
